// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch / data) arbiter in front of a single memory port.
// FSM IDLE -> ACCESS -> RESP. Memory handshake: mem_en is held high with
// mem_we/mem_addr/mem_wdata stable until the memory raises mem_ready for one
// cycle, or until TIMEOUT_CYCLES ACCESS cycles pass without mem_ready, which
// aborts the access and sets the sticky timeout_err flag.
// Optional feature: define MEM_ARB_RR_EN to get round-robin arbitration on
// contention; without it the data port always wins.
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_done,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_done,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [1:0]            dbg_state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // Counter value seen in the last allowed ACCESS cycle.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state;
  logic          grant_d;   // 1 = data port owns the current access
  logic [CW-1:0] acc_cnt;   // ACCESS cycles spent without mem_ready
  logic          pick_d;    // port chosen if a grant happens this cycle

`ifdef MEM_ARB_RR_EN
  logic          last_grant_d;

  // Round-robin: on contention give the port that did not win last time.
  always_comb begin
    pick_d = d_req;
    if (if_req && d_req) pick_d = !last_grant_d;
  end
`else
  // Fixed priority: the data port wins whenever it is requesting.
  always_comb begin
    pick_d = d_req;
  end
`endif

  assign dbg_state = state;

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant_d     <= 1'b0;
      acc_cnt     <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_rdata    <= '0;
      d_rdata     <= '0;
      if_done     <= 1'b0;
      d_done      <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant_d <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            grant_d   <= pick_d;
            mem_addr  <= pick_d ? d_addr : if_addr;
            mem_wdata <= pick_d ? d_wdata : '0;
            mem_we    <= pick_d & d_we;
            mem_en    <= 1'b1;
            busy      <= 1'b1;
            acc_cnt   <= '0;
            state     <= ACCESS;
`ifdef MEM_ARB_RR_EN
            last_grant_d <= pick_d;
`endif
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            // Normal completion; mem_ready wins over a simultaneous timeout.
            if (!mem_we) begin
              if (grant_d) d_rdata  <= mem_rdata;
              else         if_rdata <= mem_rdata;
            end
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            if_done <= !grant_d;
            d_done  <= grant_d;
            state   <= RESP;
          end else if (acc_cnt == CNT_LAST) begin
            // Abort: reads return zero, error flag is sticky.
            acc_cnt <= acc_cnt + 1'b1;
            if (!mem_we) begin
              if (grant_d) d_rdata  <= '0;
              else         if_rdata <= '0;
            end
            timeout_err <= 1'b1;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            if_done     <= !grant_d;
            d_done      <= grant_d;
            state       <= RESP;
          end else begin
            acc_cnt <= acc_cnt + 1'b1;
          end
        end
        RESP: begin
          if_done <= 1'b0;
          d_done  <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. A transaction-level model
// turns each request into a per-cycle expected timeline (ACCESS cycles, then
// one RESP cycle); cycles with no queued entry must look idle.
module tb_mem_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int TMO = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          busy;
  logic          timeout_err;
  logic [1:0]    dbg_state;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  typedef struct {
    int            cyc;
    bit            en;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit            busy;
    bit            ifd;
    bit            dd;
    logic [DW-1:0] ifr;
    logic [DW-1:0] dr;
    bit            terr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_n = 0;
  bit   chk_on = 1'b0;

  // Committed model state (updated when a done cycle is checked).
  logic [DW-1:0] m_ifr = '0;
  logic [DW-1:0] m_dr = '0;
  bit            m_terr = 1'b0;
  bit            m_last_d = 1'b0;

  // Memory responder configuration: mem_ready in ACCESS cycle mem_lat (0 = never).
  int mem_lat = 0;
  int mem_acc = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc_n, act, exp);
    end
  endtask

  // Memory model: counts ACCESS cycles and raises mem_ready on the chosen one.
  always @(negedge clk) begin
    if (mem_en) begin
      mem_acc   = mem_acc + 1;
      mem_ready = (mem_lat != 0) && (mem_acc == mem_lat);
    end else begin
      mem_acc   = 0;
      mem_ready = 1'b0;
    end
  end

  // Per-cycle compare against the model timeline.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && chk_on) begin
      if (exp_q.size() != 0 && exp_q[0].cyc == cyc_n) begin
        e = exp_q.pop_front();
      end else begin
        e = '{cyc: cyc_n, en: 1'b0, we: 1'b0, addr: '0, wdata: '0, busy: 1'b0,
              ifd: 1'b0, dd: 1'b0, ifr: m_ifr, dr: m_dr, terr: m_terr};
      end
      chk("mem_en", 32'(mem_en), 32'(e.en));
      chk("busy", 32'(busy), 32'(e.busy));
      chk("if_done", 32'(if_done), 32'(e.ifd));
      chk("d_done", 32'(d_done), 32'(e.dd));
      chk("if_rdata", 32'(if_rdata), 32'(e.ifr));
      chk("d_rdata", 32'(d_rdata), 32'(e.dr));
      chk("timeout_err", 32'(timeout_err), 32'(e.terr));
      if (e.en) begin
        chk("mem_we", 32'(mem_we), 32'(e.we));
        chk("mem_addr", 32'(mem_addr), 32'(e.addr));
        if (e.we) chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
      end
      if (e.ifd || e.dd) begin
        m_ifr  = e.ifr;
        m_dr   = e.dr;
        m_terr = e.terr;
      end
    end
  end

  // ---------------- driver ----------------
  // Called at the negedge of an IDLE cycle with the request inputs already set.
  // Builds the expected timeline, runs it, and returns at the negedge of the
  // IDLE cycle that follows the done pulse.
  task automatic serve(input int lat, input logic [DW-1:0] rval, input bit drop_mid,
                       output bit got_d);
    int            c;
    int            k;
    bit            gd;
    bit            tmo;
    bit            we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [DW-1:0] nifr;
    logic [DW-1:0] ndr;
    exp_t          e;
    c = cyc_n;
    if (if_req && d_req) begin
`ifdef MEM_ARB_RR_EN
      gd = !m_last_d;
`else
      gd = 1'b1;
`endif
    end else begin
      gd = d_req;
    end
    m_last_d  = gd;
    we        = gd ? d_we : 1'b0;
    a         = gd ? d_addr : if_addr;
    wd        = gd ? d_wdata : '0;
    tmo       = (lat == 0) || (lat > TMO);
    k         = tmo ? TMO : lat;
    mem_lat   = lat;
    mem_rdata = rval;
    for (int i = 1; i <= k; i++) begin
      e = '{cyc: c + i, en: 1'b1, we: we, addr: a, wdata: wd, busy: 1'b1,
            ifd: 1'b0, dd: 1'b0, ifr: m_ifr, dr: m_dr, terr: m_terr};
      exp_q.push_back(e);
    end
    nifr = m_ifr;
    ndr  = m_dr;
    if (!we) begin
      if (gd) ndr  = tmo ? '0 : rval;
      else    nifr = tmo ? '0 : rval;
    end
    e = '{cyc: c + k + 1, en: 1'b0, we: 1'b0, addr: '0, wdata: '0, busy: 1'b1,
          ifd: !gd, dd: gd, ifr: nifr, dr: ndr, terr: m_terr | tmo};
    exp_q.push_back(e);
    @(negedge clk);
    if (drop_mid) begin
      if (gd) d_req = 1'b0;
      else    if_req = 1'b0;
    end
    repeat (k) @(negedge clk);
    got_d = d_done;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit       g;
    bit [3:0] gseq;
    int       t_req;
    int       t_done;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    chk("rst_if_rdata", 32'(if_rdata), 32'd0);
    #2 reset = 1'b0;
    chk_on = 1'b1;
    repeat (3) @(negedge clk);

    // Fetch read, memory answers in the first ACCESS cycle.
    if_req  = 1'b1;
    if_addr = 16'h0010;
    t_req   = cyc_n;
    serve(1, 16'hBEEF, 1'b0, g);
    t_done  = cyc_n - 1;
    if_req  = 1'b0;
    chk("fetch_grant", 32'(g), 32'd0);
    chk("fetch_rdata", 32'(if_rdata), 32'hBEEF);
    chk("fetch_latency", 32'(t_done - t_req), 32'd2);
    repeat (2) @(negedge clk);

    // Data write, memory answers in the fourth ACCESS cycle.
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 16'h8000;
    d_wdata = 16'h1234;
    serve(4, 16'hDEAD, 1'b0, g);
    d_req   = 1'b0;
    d_we    = 1'b0;
    chk("write_grant", 32'(g), 32'd1);
    chk("write_rdata_kept", 32'(d_rdata), 32'd0);
    @(negedge clk);

    // Data read with the request dropped mid-access.
    d_req  = 1'b1;
    d_addr = 16'h0042;
    serve(2, 16'hA5A5, 1'b1, g);
    d_req  = 1'b0;
    chk("drop_rdata", 32'(d_rdata), 32'hA5A5);
    @(negedge clk);

    // Fetch request held through done counts as a new request.
    if_req  = 1'b1;
    if_addr = 16'h0020;
    serve(1, 16'h1111, 1'b0, g);
    serve(3, 16'h2222, 1'b0, g);
    if_req  = 1'b0;
    chk("rereq_rdata", 32'(if_rdata), 32'h2222);
    @(negedge clk);

    // mem_ready on the last allowed cycle wins over timeout.
    d_req  = 1'b1;
    d_addr = 16'h0100;
    serve(TMO, 16'h7777, 1'b0, g);
    d_req  = 1'b0;
    chk("edge_terr", 32'(timeout_err), 32'd0);
    chk("edge_rdata", 32'(d_rdata), 32'h7777);
    @(negedge clk);

    // Timeout: memory never answers.
    d_req = 1'b1;
    serve(0, 16'h9999, 1'b0, g);
    d_req = 1'b0;
    chk("tmo_rdata", 32'(d_rdata), 32'd0);
    chk("tmo_terr", 32'(timeout_err), 32'd1);
    repeat (4) @(negedge clk);
    chk("tmo_terr_held", 32'(timeout_err), 32'd1);

    // Reset during the second ACCESS cycle of a pending read.
    chk_on  = 1'b0;
    d_req   = 1'b1;
    d_addr  = 16'h0200;
    mem_lat = 0;
    repeat (2) @(negedge clk);
    chk("pre_rst_en", 32'(mem_en), 32'd1);
    #2 reset = 1'b1;
    d_req = 1'b0;
    #1;
    chk("arst_mem_en", 32'(mem_en), 32'd0);
    chk("arst_mem_we", 32'(mem_we), 32'd0);
    chk("arst_mem_addr", 32'(mem_addr), 32'd0);
    chk("arst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("arst_if_rdata", 32'(if_rdata), 32'd0);
    chk("arst_d_rdata", 32'(d_rdata), 32'd0);
    chk("arst_if_done", 32'(if_done), 32'd0);
    chk("arst_d_done", 32'(d_done), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_terr", 32'(timeout_err), 32'd0);
    chk("arst_state", 32'(dbg_state), 32'd0);
    exp_q.delete();
    m_ifr    = '0;
    m_dr     = '0;
    m_terr   = 1'b0;
    m_last_d = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    chk_on = 1'b1;
    repeat (3) @(negedge clk);

    // Contention: both ports held high for four grants.
    if_req  = 1'b1;
    if_addr = 16'h0030;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 16'h0040;
    for (int i = 0; i < 4; i++) begin
      serve(1 + i, 16'h1000 + 16'(i), 1'b0, g);
      gseq[i] = g;
    end
    if_req = 1'b0;
    d_req  = 1'b0;
`ifdef MEM_ARB_RR_EN
    chk("contention_seq", 32'(gseq), 32'b0101);
`else
    chk("contention_seq", 32'(gseq), 32'b1111);
`endif
    repeat (4) @(negedge clk);
    chk("tail_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
